// File: rtl/sram_mem_controller.sv
// MEM-stage SRAM controller: one 32-bit word access split into two 16-bit SRAM phases.
// Define SRAM_LAST_READ_EN to add a one-entry last-read buffer that answers repeat loads with no freeze.
module sram_mem_controller #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        Address,
   input  logic [31:0]        Write_Data,
   output logic [31:0]        Read_Data,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   input  logic [15:0]        SRAM_DQ_in,
   output logic [15:0]        SRAM_DQ_out,
   output logic               SRAM_DQ_oe,
   output logic               SRAM_WE_N
);

   localparam logic [3:0] LAST_CNT        = 4'(WAIT_CYCLES - 1);
   localparam logic       STROBE_OFF_FIRST = (WAIT_CYCLES == 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t             state;
   logic [3:0]         wait_cnt;
   logic               is_read;
   logic [SRAM_AW-2:0] word_q;
   logic [31:0]        wdata_q;
   logic [15:0]        low_half;
   logic [31:0]        read_q;

   logic               req;
   logic               hit;
   logic [31:0]        hit_data;
   logic [31:0]        offset;
   logic [SRAM_AW-2:0] map_word;
   logic               unused_offset_bits;

   assign req      = MEM_R_EN | MEM_W_EN;
   assign offset   = Address - BASE_ADDR;
   assign map_word = offset[SRAM_AW:2];
   assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

`ifdef SRAM_LAST_READ_EN
   logic               buf_valid;
   logic [SRAM_AW-2:0] buf_word;
   logic [31:0]        buf_data;

   assign hit      = MEM_R_EN && buf_valid && (buf_word == map_word);
   assign hit_data = buf_data;

   // Buffer tracks the last read word and stays coherent with stores to that word
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid <= 1'b0;
         buf_word  <= '0;
         buf_data  <= '0;
      end else if (state == DONE) begin
         if (is_read) begin
            buf_valid <= 1'b1;
            buf_word  <= word_q;
            buf_data  <= read_q;
         end else if (buf_valid && (buf_word == word_q)) begin
            buf_data  <= wdata_q;
         end
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_comb begin
      ready = 1'b0;
      case (state)
         IDLE:    ready = ~req | hit;
         DONE:    ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign Read_Data = ((state == IDLE) && hit) ? hit_data : read_q;

   // The strobe is released one cycle before each phase ends so write data outlives WE_N
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         is_read     <= 1'b0;
         word_q      <= '0;
         wdata_q     <= '0;
         low_half    <= '0;
         read_q      <= '0;
         SRAM_ADDR   <= '0;
         SRAM_DQ_out <= '0;
         SRAM_DQ_oe  <= 1'b0;
         SRAM_WE_N   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  read_q <= hit_data;
               end else if (req) begin
                  is_read     <= MEM_R_EN;
                  word_q      <= map_word;
                  wdata_q     <= Write_Data;
                  wait_cnt    <= '0;
                  state       <= LOW;
                  SRAM_ADDR   <= {map_word, 1'b0};
                  SRAM_DQ_out <= Write_Data[15:0];
                  SRAM_DQ_oe  <= ~MEM_R_EN;
                  SRAM_WE_N   <= MEM_R_EN ? 1'b1 : STROBE_OFF_FIRST;
               end
            end
            LOW: begin
               if (wait_cnt == LAST_CNT) begin
                  low_half    <= SRAM_DQ_in;
                  wait_cnt    <= '0;
                  state       <= HIGH;
                  SRAM_ADDR   <= {word_q, 1'b1};
                  SRAM_DQ_out <= wdata_q[31:16];
                  SRAM_WE_N   <= is_read ? 1'b1 : STROBE_OFF_FIRST;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
                  if (wait_cnt + 4'd1 == LAST_CNT) SRAM_WE_N <= 1'b1;
               end
            end
            HIGH: begin
               if (wait_cnt == LAST_CNT) begin
                  if (is_read) read_q <= {SRAM_DQ_in, low_half};
                  wait_cnt   <= '0;
                  state      <= DONE;
                  SRAM_WE_N  <= 1'b1;
                  SRAM_DQ_oe <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
                  if (wait_cnt + 4'd1 == LAST_CNT) SRAM_WE_N <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- MEM-stage responder for the decoded memory enables (MEM_R_EN, MEM_W_EN) that the control unit issues for LDR/STR.
- Converts one 32-bit word access into two sequential 16-bit SRAM half-word accesses, each with configurable wait states.
- Drives ready low to freeze the pipeline until the access completes.
- Returns the read word to the WB stage.

Parameters:
- WAIT_CYCLES, 2: cycles each half-word phase is held on the SRAM pins (legal values 1..15).
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- MEM_R_EN  in  1  load request from the MEM stage
- MEM_W_EN  in  1  store request from the MEM stage
- Address  in  32  byte address (ALU result); word-aligned
- Write_Data  in  32  store data (Val_Rm)
- Read_Data  out  32  load result; valid while ready=1 in DONE
- ready  out  1  0 = freeze pipeline; combinational from state and request
- SRAM_ADDR  out  SRAM_AW  half-word address
- SRAM_DQ_in  in  16  SRAM read data
- SRAM_DQ_out  out  16  SRAM write data
- SRAM_DQ_oe  out  1  1 = controller drives the DQ bus
- SRAM_WE_N  out  1  active-low write strobe

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, wait counter=0.
  - Read_Data=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1.
  - Reset mid-access aborts immediately; no partial completion is signalled.
- Address mapping:
  - word = (Address - BASE_ADDR) >> 2, 32-bit subtract with wrap.
  - Low half-word address = {word[SRAM_AW-2:0], 1'b0}; high = low | 1.
  - Address[1:0] are ignored.
- Request: req = MEM_R_EN | MEM_W_EN. If both are high, the access is a read and the write is ignored.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE:
    - ready = ~req.
    - If req: latch direction, mapped address and Write_Data; go to LOW with counter=0.
  - LOW:
    - SRAM_ADDR = low address.
    - Write: SRAM_DQ_oe=1, SRAM_DQ_out=Write_Data[15:0], SRAM_WE_N=0 for all cycles except the last, where SRAM_WE_N=1 so data holds past the strobe.
    - Read: SRAM_DQ_oe=0, SRAM_WE_N=1; Read_Data[15:0] captured from SRAM_DQ_in on the last cycle.
    - Counter increments each cycle. When counter = WAIT_CYCLES-1, go to HIGH with counter=0.
  - HIGH: same as LOW with the high address and bits [31:16]; then go to DONE.
  - DONE:
    - ready=1, Read_Data valid, SRAM_WE_N=1, SRAM_DQ_oe=0.
    - Always go to IDLE next cycle. The pipeline advances on this edge, so the same instruction is never serviced twice.
  - ready=0 in LOW and HIGH.
- Latency:
  - ready is low for 1+2*WAIT_CYCLES cycles starting with the request cycle; high in the following DONE cycle.
  - WAIT_CYCLES=2 gives 5 freeze cycles.
- Read_Data holds its last value outside DONE; a write never modifies it.
- Back-to-back accesses: a request present in IDLE right after DONE starts a new access with no extra idle cycle.
- Request inputs are sampled only in IDLE. Changes to them in LOW, HIGH or DONE are ignored.

Optional Feature:
- Macro SRAM_LAST_READ_EN.
- Defined:
  - A one-entry buffer (valid bit, word address, data) is loaded in DONE of every read.
  - A read in IDLE whose mapped word matches a valid entry is a hit: ready stays 1, Read_Data = buffered data in the same cycle (combinational bypass), and the state stays IDLE.
  - A write to the buffered word updates the buffered data in DONE.
  - Reset clears the valid bit.
- Not defined:
  - No buffer logic; every read takes the full latency.

Test Plan:
- Reset: assert rst during a HIGH phase -> next cycle state IDLE, SRAM_WE_N=1, SRAM_DQ_oe=0, Read_Data=0, ready=1 with no request.
- Store (Address=1024, Write_Data=0xDEADBEEF, WAIT_CYCLES=2):
  - SRAM_ADDR=0 carrying 0xBEEF with WE_N low for 1 cycle.
  - Then SRAM_ADDR=1 carrying 0xDEAD.
  - ready low for 5 cycles, high on the 6th.
- Load (Address=1032): SRAM model returns 0x1234 at addr 4 and 0xABCD at addr 5 -> Read_Data=0xABCD1234 with ready=1 exactly in the DONE cycle.
- Simultaneous MEM_R_EN=MEM_W_EN=1 -> read performed, SRAM_WE_N never low.
- Store followed directly by load in consecutive instructions -> second access starts in the cycle after DONE; total freeze 10 cycles; the load returns the stored value.
- SRAM_LAST_READ_EN:
  - Two loads from 1040 -> second one: ready never drops, data correct.
  - Store 0x55AA55AA to 1040, then load -> hit returns 0x55AA55AA.
